rx_descrambler_unpack: RTL and testbench

- Receive-chain stage directly downstream of the Viterbi decoder.
- Consumes the decoder's serial hard-decision bit stream (one bit per cycle while the decoder's Valid is high).
- Recovers the 802.11a scrambler seed from the SERVICE field, descrambles the stream, drops SERVICE and the trailing tail/pad bits, and packs PSDU bits into bytes (first bit received = byte LSB) for the MAC interface.

---
 rtl/rx_pkg.sv | 29 ++
 rtl/scrambler_lfsr7.sv | 48 ++++
 rtl/rx_descrambler_unpack.sv | 177 +++++++++++++++++
 tb/tb_rx_descrambler_unpack.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_pkg
// Description : Shared definitions for the receive descrambler/unpacker and
//               the 7-bit 802.11a scrambler LFSR: FSM state encoding, SERVICE
//               field geometry and LFSR tap positions.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_pkg;

  // DRAIN is reserved and behaves exactly like DONE.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_SERVICE = 3'd2,
    ST_DATA    = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_DONE    = 3'd5
  } rx_state_e;

  localparam int SERVICE_BITS = 16;
  localparam int SEED_BITS    = 7;

  // Polynomial x^7 + x^4 + 1: feedback is S[6] ^ S[3].
  localparam int LFSR_TAP_HI  = 6;
  localparam int LFSR_TAP_LO  = 3;

endpackage
`default_nettype wire

// File: rtl/scrambler_lfsr7.sv
`default_nettype none
// ============================================================================
// Module      : scrambler_lfsr7
// Description : 7-bit 802.11a scrambler/descrambler LFSR (x^7 + x^4 + 1).
//               LoadMode=1 : S <= {S[5:0], BitIn}, BitOut = BitIn (seed load)
//               LoadMode=0 : S <= {S[5:0], f},     BitOut = BitIn ^ f
//               where f = S[6] ^ S[3]. State only moves when Advance=1.
// Ports       : Clk, Reset (sync, active-high clear), LoadMode, Advance,
//               BitIn, BitOut (combinational), State (registered S[6:0]).
// Revision    : 1.0 - initial release
// ============================================================================
module scrambler_lfsr7
  import rx_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       LoadMode,
  input  logic       Advance,
  input  logic       BitIn,
  output logic       BitOut,
  output logic [6:0] State
);

  logic [6:0] s_q;
  logic [6:0] s_d;
  logic       fb;

  always_comb begin
    fb     = s_q[LFSR_TAP_HI] ^ s_q[LFSR_TAP_LO];
    s_d    = s_q;
    BitOut = LoadMode ? BitIn : (BitIn ^ fb);
    if (Advance) begin
      s_d = {s_q[5:0], (LoadMode ? BitIn : fb)};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end

  assign State = s_q;

endmodule
`default_nettype wire

// File: rtl/rx_descrambler_unpack.sv
`default_nettype none
// ============================================================================
// Module      : rx_descrambler_unpack
// Description : Sits after the Viterbi decoder. Recovers the scrambler seed
//               from the first 7 SERVICE bits, descrambles the remainder,
//               checks the reserved SERVICE bits, drops SERVICE and tail/pad,
//               and packs PSDU bits into bytes (first bit = LSB).
// Ports       : Clk, Reset (sync, active-high), Start (frame enable level),
//               BitIn/BitValid (decoder output), PsduLength (bytes, sampled
//               on first accepted bit), DataOut/DataValid (byte strobe),
//               Done (level), SeedOut (recovered seed), SeedErr (sticky).
// Revision    : 1.0 - initial release
// ============================================================================
module rx_descrambler_unpack
  import rx_pkg::*;
#(
  parameter int LEN_W        = 12,
  parameter int SERVICE_BITS = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             BitIn,
  input  logic             BitValid,
  input  logic [LEN_W-1:0] PsduLength,
  output logic [7:0]       DataOut,
  output logic             DataValid,
  output logic             Done,
  output logic [6:0]       SeedOut,
  output logic             SeedErr
);

  localparam int BC_W = $clog2(SERVICE_BITS + 1);

  rx_state_e        state_q, state_d;
  logic [BC_W-1:0]  bitcnt_q, bitcnt_d;
  logic [2:0]       bitpos_q, bitpos_d;
  logic [LEN_W-1:0] bytecnt_q, bytecnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [7:0]       byte_sr_q, byte_sr_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic [6:0]       seed_q, seed_d;
  logic             seed_err_q, seed_err_d;

  logic             clear;
  logic             accept;
  logic             lfsr_load;
  logic             lfsr_adv;
  logic             lfsr_bit;
  logic [6:0]       lfsr_state;
  logic [6:0]       seed_next;
  logic [LEN_W-1:0] bytecnt_inc;

  // Start low behaves exactly like reset, including the LFSR.
  assign clear  = Reset | ~Start;
  assign accept = Start & BitValid;

  scrambler_lfsr7 u_lfsr (
    .Clk      (Clk),
    .Reset    (clear),
    .LoadMode (lfsr_load),
    .Advance  (lfsr_adv),
    .BitIn    (BitIn),
    .BitOut   (lfsr_bit),
    .State    (lfsr_state)
  );

  // LFSR contents after the current seed bit is shifted in.
  assign seed_next   = {lfsr_state[5:0], BitIn};
  assign bytecnt_inc = bytecnt_q + LEN_W'(1);

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    bitpos_d     = bitpos_q;
    bytecnt_d    = bytecnt_q;
    len_d        = len_q;
    byte_sr_d    = byte_sr_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    seed_d       = seed_q;
    seed_err_d   = seed_err_q;
    lfsr_load    = 1'b1;
    lfsr_adv     = 1'b0;

    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          len_d    = PsduLength;
          lfsr_adv = 1'b1;
          bitcnt_d = BC_W'(1);
          state_d  = ST_SEED;
        end

        ST_SEED: begin
          lfsr_adv = 1'b1;
          bitcnt_d = bitcnt_q + BC_W'(1);
          if (bitcnt_q == BC_W'(SEED_BITS - 1)) begin
            seed_d = seed_next;
            if (seed_next == 7'd0) begin
              seed_err_d = 1'b1;
            end
            state_d = ST_SERVICE;
          end
        end

        ST_SERVICE: begin
          lfsr_load = 1'b0;
          lfsr_adv  = 1'b1;
          bitcnt_d  = bitcnt_q + BC_W'(1);
          // Reserved SERVICE bits must descramble to zero.
          if (lfsr_bit) begin
            seed_err_d = 1'b1;
          end
          if (bitcnt_q == BC_W'(SERVICE_BITS - 1)) begin
            state_d = (len_q == '0) ? ST_DONE : ST_DATA;
          end
        end

        ST_DATA: begin
          lfsr_load           = 1'b0;
          lfsr_adv            = 1'b1;
          byte_sr_d[bitpos_q] = lfsr_bit;
          bitpos_d            = bitpos_q + 3'd1;
          if (bitpos_q == 3'd7) begin
            data_out_d   = {lfsr_bit, byte_sr_q[6:0]};
            data_valid_d = 1'b1;
            bytecnt_d    = bytecnt_inc;
            // bytecnt_q < len_q always holds here, so the increment cannot wrap.
            if (bytecnt_inc == len_q) begin
              state_d = ST_DONE;
            end
          end
        end

        default: begin
          // DONE / DRAIN: tail and pad bits are discarded.
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (clear) begin
      state_q      <= ST_IDLE;
      bitcnt_q     <= '0;
      bitpos_q     <= '0;
      bytecnt_q    <= '0;
      len_q        <= '0;
      byte_sr_q    <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      seed_q       <= '0;
      seed_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      bitpos_q     <= bitpos_d;
      bytecnt_q    <= bytecnt_d;
      len_q        <= len_d;
      byte_sr_q    <= byte_sr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      seed_q       <= seed_d;
      seed_err_q   <= seed_err_d;
    end
  end

  assign DataOut   = data_out_q;
  assign DataValid = data_valid_q;
  assign Done      = (state_q == ST_DONE) || (state_q == ST_DRAIN);
  assign SeedOut   = seed_q;
  assign SeedErr   = seed_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_descrambler_unpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_descrambler_unpack
// Description : Self-checking bench for rx_descrambler_unpack. A sequence-
//               level model (scrambler key as the recurrence
//               p[k] = p[k-7] ^ p[k-4]) predicts every output each cycle;
//               directed frames add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_descrambler_unpack;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        BitIn;
  logic        BitValid;
  logic [11:0] PsduLength;
  logic [7:0]  DataOut;
  logic        DataValid;
  logic        Done;
  logic [6:0]  SeedOut;
  logic        SeedErr;

  always #5 Clk = ~Clk;

  rx_descrambler_unpack #(.LEN_W(12), .SERVICE_BITS(16)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .BitIn      (BitIn),
    .BitValid   (BitValid),
    .PsduLength (PsduLength),
    .DataOut    (DataOut),
    .DataValid  (DataValid),
    .Done       (Done),
    .SeedOut    (SeedOut),
    .SeedErr    (SeedErr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: key sequence of the current frame and derived outputs.
  bit          key_q[$];
  int          m_k    = 0;
  int          m_len  = 0;
  logic [7:0]  m_acc  = '0;
  logic [7:0]  m_data = '0;
  logic        m_dv   = 1'b0;
  logic        m_done = 1'b0;
  logic        m_err  = 1'b0;
  logic [6:0]  m_seed = '0;

  // Expected DUT outputs after the most recent clock edge.
  logic [7:0]  e_data = '0;
  logic        e_dv   = 1'b0;
  logic        e_done = 1'b0;
  logic        e_err  = 1'b0;
  logic [6:0]  e_seed = '0;
  bit          chk_en = 1'b0;

  logic [7:0]  cap_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  psdu_q[$];
  bit          tx_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("DataValid", int'(DataValid), int'(e_dv));
      chk("DataOut",   int'(DataOut),   int'(e_data));
      chk("Done",      int'(Done),      int'(e_done));
      chk("SeedOut",   int'(SeedOut),   int'(e_seed));
      chk("SeedErr",   int'(SeedErr),   int'(e_err));
      if (DataValid) cap_q.push_back(DataOut);
    end
  end

  task automatic model_step(input bit rst, input bit st, input bit v, input bit b, input int len);
    bit p;
    bit d;
    int j;
    m_dv = 1'b0;
    if (rst || !st) begin
      key_q.delete();
      m_k = 0; m_done = 1'b0; m_err = 1'b0; m_seed = '0; m_data = '0; m_acc = '0;
    end else if (v && !m_done) begin
      if (m_k < 7) begin
        key_q.push_back(b);
        if (m_k == 0) m_len = len;
        if (m_k == 6) begin
          for (int i = 0; i < 7; i++) m_seed[6-i] = key_q[i];
          if (m_seed == 7'd0) m_err = 1'b1;
        end
      end else begin
        p = key_q[m_k-7] ^ key_q[m_k-4];
        key_q.push_back(p);
        d = b ^ p;
        if (m_k < 16) begin
          if (d) m_err = 1'b1;
          if (m_k == 15 && m_len == 0) m_done = 1'b1;
        end else begin
          j = m_k - 16;
          m_acc[j%8] = d;
          if (j % 8 == 7) begin
            m_dv = 1'b1;
            m_data = m_acc;
            if (j / 8 + 1 == m_len) m_done = 1'b1;
          end
        end
      end
      m_k++;
    end
  endtask

  task automatic step(input bit rst, input bit st, input bit v, input bit b, input int len);
    Reset = rst; Start = st; BitValid = v; BitIn = b; PsduLength = len[11:0];
    model_step(rst, st, v, b, len);
    @(posedge Clk);
    #1;
    e_dv = m_dv; e_data = m_data; e_done = m_done; e_err = m_err; e_seed = m_seed;
  endtask

  // Scrambled transmit stream: 16 SERVICE bits (all zero), PSDU LSB first,
  // then unscrambled zero tail bits.
  task automatic build(input logic [6:0] seed, input int tail);
    bit kq[$];
    bit p;
    bit d;
    int nb;
    logic [7:0] by;
    nb = 16 + psdu_q.size() * 8;
    tx_q.delete();
    for (int k = 0; k < nb; k++) begin
      if (k < 7) p = seed[6-k];
      else       p = kq[k-7] ^ kq[k-4];
      kq.push_back(p);
      if (k < 16) d = 1'b0;
      else begin
        by = psdu_q[(k-16)/8];
        d  = by[(k-16)%8];
      end
      tx_q.push_back(d ^ p);
    end
    for (int t = 0; t < tail; t++) tx_q.push_back(1'b0);
  endtask

  task automatic drive(input int from, input int to, input int len, input bit gap);
    for (int i = from; i < to; i++) begin
      step(1'b0, 1'b1, 1'b1, tx_q[i], len);
      if (gap) step(1'b0, 1'b1, 1'b0, bit'($urandom_range(1, 0)), len);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic chk_bytes(input string name);
    chk({name, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      chk(name, int'(cap_q[i]), int'(exp_q[i]));
  endtask

  initial begin
    int pin;
    Reset = 1'b1; Start = 1'b0; BitValid = 1'b0; BitIn = 1'b0; PsduLength = '0;

    // Reset state
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    chk_en = 1'b1;
    chk("rst_DataOut", int'(DataOut), 0);
    chk("rst_DataValid", int'(DataValid), 0);
    chk("rst_Done", int'(Done), 0);
    chk("rst_SeedOut", int'(SeedOut), 0);
    chk("rst_SeedErr", int'(SeedErr), 0);
    idle(2);

    // Frame 1: seed 1011101, 4 zero bytes, contiguous
    psdu_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    build(7'b1011101, 6);
    pin = 0;
    for (int k = 7; k < 16; k++) pin = (pin << 1) | int'(tx_q[k]);
    chk("key_bits_7_15", pin, 9'b011011000);
    cap_q.delete();
    drive(0, 7, 4, 1'b0);
    chk("f1_SeedOut", int'(SeedOut), 7'h5D);
    drive(7, 47, 4, 1'b0);
    chk("f1_done_before_last", int'(Done), 0);
    drive(47, 48, 4, 1'b0);
    chk("f1_done_after_48", int'(Done), 1);
    drive(48, tx_q.size(), 4, 1'b0);
    chk("f1_SeedErr", int'(SeedErr), 0);
    exp_q = '{8'h00, 8'h00, 8'h00, 8'h00};
    chk_bytes("f1_bytes");
    idle(2);

    // Frame 2: BitValid toggling
    psdu_q = '{8'hA5, 8'h3C, 8'hFF};
    build(7'b1011101, 6);
    cap_q.delete();
    drive(0, tx_q.size(), 3, 1'b1);
    exp_q = '{8'hA5, 8'h3C, 8'hFF};
    chk_bytes("f2_bytes");
    chk("f2_Done", int'(Done), 1);
    idle(2);

    // Frame 3: len 0
    psdu_q.delete();
    build(7'b1011101, 6);
    cap_q.delete();
    drive(0, 15, 0, 1'b0);
    chk("f3_done_before_16", int'(Done), 0);
    drive(15, 16, 0, 1'b0);
    chk("f3_done_after_16", int'(Done), 1);
    drive(16, tx_q.size(), 0, 1'b0);
    chk("f3_no_strobes", cap_q.size(), 0);
    idle(2);

    // Frame 4: flipped SERVICE bit 10
    psdu_q = '{8'h5A, 8'hC3};
    build(7'b1011101, 6);
    tx_q[10] = ~tx_q[10];
    cap_q.delete();
    drive(0, 10, 2, 1'b0);
    chk("f4_err_before", int'(SeedErr), 0);
    drive(10, 11, 2, 1'b0);
    chk("f4_err_after", int'(SeedErr), 1);
    drive(11, tx_q.size(), 2, 1'b0);
    exp_q = '{8'h5A, 8'hC3};
    chk_bytes("f4_bytes");
    chk("f4_err_sticky", int'(SeedErr), 1);
    idle(2);

    // Frame 5: all-zero seed
    psdu_q = '{8'h12};
    build(7'b0000000, 6);
    cap_q.delete();
    drive(0, 6, 1, 1'b0);
    chk("f5_err_before", int'(SeedErr), 0);
    drive(6, 7, 1, 1'b0);
    chk("f5_err_after7", int'(SeedErr), 1);
    drive(7, tx_q.size(), 1, 1'b0);
    exp_q = '{8'h12};
    chk_bytes("f5_bytes");
    idle(2);

    // Frame 6: abort after 3 bits of byte 2, then new frame 0x81
    psdu_q = '{8'h11, 8'h22, 8'h33};
    build(7'b1011101, 6);
    cap_q.delete();
    drive(0, 27, 3, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, bit'($urandom_range(1, 0)), 3);
    chk("f6_abort_DataOut", int'(DataOut), 0);
    chk("f6_abort_SeedOut", int'(SeedOut), 0);
    chk("f6_abort_Done", int'(Done), 0);
    psdu_q = '{8'h81};
    build(7'h2A, 6);
    drive(0, tx_q.size(), 1, 1'b0);
    exp_q = '{8'h11, 8'h81};
    chk_bytes("f6_bytes");
    chk("f6_Done", int'(Done), 1);
    idle(2);

    // Frame 7: Start falls on the last PSDU bit
    psdu_q = '{8'h77};
    build(7'h33, 0);
    cap_q.delete();
    drive(0, 23, 1, 1'b0);
    step(1'b0, 1'b0, 1'b1, tx_q[23], 1);
    chk("f7_no_strobe", int'(DataValid), 0);
    idle(2);
    chk("f7_no_bytes", cap_q.size(), 0);

    // Frame 8: maximum length, no counter wrap
    psdu_q.delete();
    for (int i = 0; i < 4095; i++) psdu_q.push_back(8'((i * 7) & 8'hFF));
    build(7'h7F, 6);
    cap_q.delete();
    drive(0, tx_q.size() - 7, 4095, 1'b0);
    chk("f8_done_before_last", int'(Done), 0);
    drive(tx_q.size() - 7, tx_q.size(), 4095, 1'b0);
    chk("f8_Done", int'(Done), 1);
    exp_q = psdu_q;
    chk_bytes("f8_bytes");
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
